// File: rtl/wishbone_slave_regs_pkg.sv
// Shared Wishbone definitions: register indices, FSM state encoding,
// default device ID and the master's command codes.
package wishbone_slave_regs_pkg;

    // Register map indices
    localparam int REG_ID       = 0;
    localparam int REG_CTRL     = 1;
    localparam int REG_IRQ_PEND = 2;
    localparam int REG_IRQ_EN   = 3;

    localparam logic [31:0] DEFAULT_DEVICE_ID = 32'h0001_0001;

    // Responder handshake FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } wb_state_e;

    // Command codes understood by the Wishbone master
    typedef enum logic [1:0] {
        CMD_NOP    = 2'd0,
        CMD_READ   = 2'd1,
        CMD_WRITE  = 2'd2,
        CMD_STREAM = 2'd3
    } wb_cmd_e;

    // True when no address bit at or above 'bits' is set
    function automatic logic addr_in_range(input logic [31:0] addr, input int bits);
        return (addr >> bits) == 32'd0;
    endfunction

endpackage

// File: rtl/wishbone_slave_regs_if.sv
// Wishbone bus bundle between the master and this register responder.
//
// Handshake: the master raises cyc, str and sel together with a stable
// addr/we/msk/dat and holds them until it sees ack. The responder raises ack
// (with read data on dat_o) once the access is served and holds it until the
// master drops str or cyc; ack falls on the next edge and a new strobe is
// taken no earlier than the cycle after ack has fallen.
interface wishbone_slave_regs_if;
    logic [31:0] wb_addr_i;
    logic [31:0] wb_dat_i;
    logic [31:0] wb_dat_o;
    logic        wb_str_i;
    logic        wb_cyc_i;
    logic        wb_we_i;
    logic        wb_msk_i;
    logic        wb_sel_i;
    logic        wb_ack_o;

    modport master (
        output wb_addr_i, wb_dat_i, wb_str_i, wb_cyc_i, wb_we_i, wb_msk_i, wb_sel_i,
        input  wb_dat_o, wb_ack_o
    );

    modport slave (
        input  wb_addr_i, wb_dat_i, wb_str_i, wb_cyc_i, wb_we_i, wb_msk_i, wb_sel_i,
        output wb_dat_o, wb_ack_o
    );
endinterface

// File: rtl/wishbone_slave_regs_handshake.sv
// IDLE/WAIT/ACK strobe handshake with programmable wait states. Latches the
// request on acceptance and emits a one-cycle access strobe on the first ACK
// cycle so the register bank commits each write exactly once.
module wishbone_slave_regs_handshake
    import wishbone_slave_regs_pkg::*;
#(
    parameter int WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cyc,
    input  logic        str,
    input  logic        sel,
    input  logic        we,
    input  logic        msk,
    input  logic [31:0] addr,
    input  logic [31:0] dat,
    output logic        ack,
    output logic        access,
    output logic [31:0] lat_addr,
    output logic [31:0] lat_dat,
    output logic        lat_we,
    output logic        lat_msk,
    output wb_state_e   state
);

    // Last value of the wait counter before moving on to ACK
    localparam logic [3:0] WAIT_LAST = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

    wb_state_e  state_next;
    logic [3:0] wait_cnt;
    logic [3:0] wait_cnt_next;
    logic       first_ack;
    logic       start;
    logic       held;

    assign start = cyc & str & sel;
    assign held  = cyc & str;

    // State, wait counter, first-ACK marker and request latch
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            wait_cnt  <= 4'd0;
            first_ack <= 1'b0;
            lat_addr  <= 32'd0;
            lat_dat   <= 32'd0;
            lat_we    <= 1'b0;
            lat_msk   <= 1'b0;
        end else begin
            state     <= state_next;
            wait_cnt  <= wait_cnt_next;
            first_ack <= (state_next == ST_ACK) && (state != ST_ACK);
            if (state == ST_IDLE && start) begin
                lat_addr <= addr;
                lat_dat  <= dat;
                lat_we   <= we;
                lat_msk  <= msk;
            end
        end
    end

    // Next-state and wait-count decisions; a dropped cyc/str aborts a wait
    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        case (state)
            ST_IDLE: begin
                wait_cnt_next = 4'd0;
                if (start) begin
                    state_next = (WAIT_STATES > 0) ? ST_WAIT : ST_ACK;
                end
            end
            ST_WAIT: begin
                if (!held) begin
                    state_next    = ST_IDLE;
                    wait_cnt_next = 4'd0;
                end else if (wait_cnt == WAIT_LAST) begin
                    state_next    = ST_ACK;
                    wait_cnt_next = 4'd0;
                end else begin
                    wait_cnt_next = wait_cnt + 4'd1;
                end
            end
            ST_ACK: begin
                if (!held) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next    = ST_IDLE;
                wait_cnt_next = 4'd0;
            end
        endcase
    end

    assign ack    = (state == ST_ACK);
    assign access = (state == ST_ACK) && first_ack;

endmodule

// File: rtl/wishbone_slave_regs.sv
// Wishbone register responder: read-only ID at reg 0, control at reg 1,
// scratch above. Build macro WB_SLAVE_INTERRUPT_EN turns regs 2/3 into an
// interrupt pending (W1C) / enable pair and adds irq_src_i and wb_int_o.
module wishbone_slave_regs
    import wishbone_slave_regs_pkg::*;
#(
    parameter int          ADDR_BITS   = 4,
    parameter int          WAIT_STATES = 0,
    parameter logic [31:0] DEVICE_ID   = DEFAULT_DEVICE_ID
) (
    input  logic        clk,
    input  logic        rst,
    wishbone_slave_regs_if.slave bus,
    output logic [31:0] ctrl_o,
    output wb_state_e   dbg_state
`ifdef WB_SLAVE_INTERRUPT_EN
    ,
    input  logic [31:0] irq_src_i,
    output logic        wb_int_o
`endif
);

    localparam int NREGS = 2 ** ADDR_BITS;

    logic                 ack;
    logic                 access;
    logic [31:0]          lat_addr;
    logic [31:0]          lat_dat;
    logic                 lat_we;
    logic                 lat_msk;
    logic [ADDR_BITS-1:0] idx;
    logic                 in_range;
    logic                 wr_en;
    logic [31:0]          rd_val;

    // Storage for every writable index; reg 0 is the constant ID
    logic [31:0] bank [1:NREGS-1];

    wishbone_slave_regs_handshake #(
        .WAIT_STATES(WAIT_STATES)
    ) u_handshake (
        .clk      (clk),
        .rst      (rst),
        .cyc      (bus.wb_cyc_i),
        .str      (bus.wb_str_i),
        .sel      (bus.wb_sel_i),
        .we       (bus.wb_we_i),
        .msk      (bus.wb_msk_i),
        .addr     (bus.wb_addr_i),
        .dat      (bus.wb_dat_i),
        .ack      (ack),
        .access   (access),
        .lat_addr (lat_addr),
        .lat_dat  (lat_dat),
        .lat_we   (lat_we),
        .lat_msk  (lat_msk),
        .state    (dbg_state)
    );

    assign idx      = lat_addr[ADDR_BITS-1:0];
    assign in_range = addr_in_range(lat_addr, ADDR_BITS);
    assign wr_en    = access & lat_we & ~lat_msk & in_range & (idx != '0);

`ifdef WB_SLAVE_INTERRUPT_EN
    logic [31:0] irq_prev;
    logic [31:0] pend_set;
    logic [31:0] pend_clr;

    assign pend_set = irq_src_i & ~irq_prev;
    assign pend_clr = (wr_en && idx == ADDR_BITS'(REG_IRQ_PEND)) ? lat_dat : 32'd0;

    // Edge detector history and registered interrupt output
    always_ff @(posedge clk) begin
        if (rst) begin
            irq_prev <= 32'd0;
            wb_int_o <= 1'b0;
        end else begin
            irq_prev <= irq_src_i;
            wb_int_o <= |(bank[REG_IRQ_PEND] & bank[REG_IRQ_EN]);
        end
    end
`endif

    // Register bank: commit writes on the access strobe
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 1; i < NREGS; i++) begin
                bank[i] <= 32'd0;
            end
        end else begin
            for (int i = 1; i < NREGS; i++) begin
                if (wr_en && idx == ADDR_BITS'(i)) begin
                    bank[i] <= lat_dat;
                end
            end
`ifdef WB_SLAVE_INTERRUPT_EN
            // Pending overrides the plain write above: W1C, new edges win
            bank[REG_IRQ_PEND] <= (bank[REG_IRQ_PEND] & ~pend_clr) | pend_set;
`endif
        end
    end

    // Read mux over the latched address
    always_comb begin
        rd_val = 32'd0;
        if (in_range) begin
            if (idx == '0) begin
                rd_val = DEVICE_ID;
            end else begin
                rd_val = bank[idx];
            end
        end
    end

    assign bus.wb_ack_o = ack;
    assign bus.wb_dat_o = (ack && !lat_we) ? rd_val : 32'd0;
    assign ctrl_o       = bank[REG_CTRL];

endmodule

// File: tb/tb_wishbone_slave_regs.sv
// Bench for wishbone_slave_regs: one instance with no wait states and one
// with three, driven by directed and random bus transactions and checked
// against a register-map model.
module tb_wishbone_slave_regs;
    import wishbone_slave_regs_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // ---------------- bus drive ----------------
    wishbone_slave_regs_if bus0 ();
    wishbone_slave_regs_if bus1 ();

    logic [31:0] addr [2];
    logic [31:0] wdat [2];
    logic        cyc  [2];
    logic        str  [2];
    logic        sel  [2];
    logic        we   [2];
    logic        msk  [2];

    assign bus0.wb_addr_i = addr[0];
    assign bus0.wb_dat_i  = wdat[0];
    assign bus0.wb_cyc_i  = cyc[0];
    assign bus0.wb_str_i  = str[0];
    assign bus0.wb_sel_i  = sel[0];
    assign bus0.wb_we_i   = we[0];
    assign bus0.wb_msk_i  = msk[0];
    assign bus1.wb_addr_i = addr[1];
    assign bus1.wb_dat_i  = wdat[1];
    assign bus1.wb_cyc_i  = cyc[1];
    assign bus1.wb_str_i  = str[1];
    assign bus1.wb_sel_i  = sel[1];
    assign bus1.wb_we_i   = we[1];
    assign bus1.wb_msk_i  = msk[1];

    logic [31:0] ctrl0, ctrl1;
    wb_state_e   st0, st1;
`ifdef WB_SLAVE_INTERRUPT_EN
    logic [31:0] irq0, irq1;
    logic        int0, int1;
`endif

    wishbone_slave_regs #(.ADDR_BITS(4), .WAIT_STATES(0)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0), .ctrl_o(ctrl0), .dbg_state(st0)
`ifdef WB_SLAVE_INTERRUPT_EN
        , .irq_src_i(irq0), .wb_int_o(int0)
`endif
    );

    wishbone_slave_regs #(.ADDR_BITS(4), .WAIT_STATES(3)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1), .ctrl_o(ctrl1), .dbg_state(st1)
`ifdef WB_SLAVE_INTERRUPT_EN
        , .irq_src_i(irq1), .wb_int_o(int1)
`endif
    );

    // ---------------- scoreboard ----------------
    int errors = 0;
    int checks = 0;
    logic [31:0] mregs [2][16];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int ws_of(input int d);
        return (d == 1) ? 3 : 0;
    endfunction

    function automatic logic ack_of(input int d);
        return (d == 1) ? bus1.wb_ack_o : bus0.wb_ack_o;
    endfunction

    function automatic logic [31:0] dat_of(input int d);
        return (d == 1) ? bus1.wb_dat_o : bus0.wb_dat_o;
    endfunction

    function automatic logic [31:0] ctrl_of(input int d);
        return (d == 1) ? ctrl1 : ctrl0;
    endfunction

    function automatic logic [31:0] exp_read(input int d, input logic [31:0] a);
        if ((a >> 4) != 32'd0) return 32'd0;
        if (a[3:0] == 4'd0) return 32'h0001_0001;
        return mregs[d][a[3:0]];
    endfunction

    task automatic model_write(input int d, input logic [31:0] a, input logic [31:0] data,
                               input logic m);
        if ((a >> 4) == 32'd0 && a[3:0] != 4'd0 && !m) begin
`ifdef WB_SLAVE_INTERRUPT_EN
            if (a[3:0] == 4'd2) mregs[d][2] = mregs[d][2] & ~data;
            else mregs[d][a[3:0]] = data;
`else
            mregs[d][a[3:0]] = data;
`endif
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 16; i++) mregs[d][i] = 32'd0;
    endtask

    // ---------------- driver tasks ----------------
    task automatic bus_idle(input int d);
        cyc[d] = 1'b0; str[d] = 1'b0; sel[d] = 1'b0;
        we[d] = 1'b0; msk[d] = 1'b0; addr[d] = 32'd0; wdat[d] = 32'd0;
    endtask

    // Full transaction: strobe, wait for ack, check latency/data, release
    task automatic xfer(input int d, input logic w, input logic m,
                        input logic [31:0] a, input logic [31:0] wd);
        int   lat;
        logic got_ack;
        addr[d] = a; wdat[d] = wd; we[d] = w; msk[d] = m;
        cyc[d] = 1'b1; str[d] = 1'b1; sel[d] = 1'b1;
        lat = 0;
        got_ack = 1'b0;
        while (!got_ack && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            got_ack = ack_of(d);
        end
        check("ack_seen", 32'(got_ack), 32'd1);
        if (got_ack) begin
            check("latency", lat, 1 + ws_of(d));
            if (!w) check("rdata", dat_of(d), exp_read(d, a));
            else check("wr_dat_zero", dat_of(d), 32'd0);
        end
        bus_idle(d);
        @(posedge clk); #1;
        check("ack_drop", 32'(ack_of(d)), 32'd0);
        check("dat_drop", dat_of(d), 32'd0);
        if (w && got_ack) model_write(d, a, wd, m);
        check("ctrl", ctrl_of(d), mregs[d][1]);
    endtask

    // Write strobe dropped during the second wait cycle
    task automatic abort_write(input int d, input logic [31:0] a, input logic [31:0] wd);
        logic seen;
        addr[d] = a; wdat[d] = wd; we[d] = 1'b1; msk[d] = 1'b0;
        cyc[d] = 1'b1; str[d] = 1'b1; sel[d] = 1'b1;
        @(posedge clk); #1;
        check("abort_wait1", 32'(ack_of(d)), 32'd0);
        @(posedge clk); #1;
        check("abort_wait2", 32'(ack_of(d)), 32'd0);
        str[d] = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            seen = seen | ack_of(d);
        end
        check("abort_no_ack", 32'(seen), 32'd0);
        bus_idle(d);
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus_idle(0);
        bus_idle(1);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // ---------------- main sequence ----------------
    initial begin
        int n;
        logic [31:0] a;
`ifdef WB_SLAVE_INTERRUPT_EN
        irq0 = 32'd0;
        irq1 = 32'd0;
`endif
        do_reset();

        // reset state
        for (int d = 0; d < 2; d++) begin
            check("rst_ack", 32'(ack_of(d)), 32'd0);
            check("rst_dat", dat_of(d), 32'd0);
            check("rst_ctrl", ctrl_of(d), 32'd0);
        end
        check("rst_state0", 32'(st0), 32'(ST_IDLE));
        check("rst_state1", 32'(st1), 32'(ST_IDLE));
`ifdef WB_SLAVE_INTERRUPT_EN
        check("rst_int0", 32'(int0), 32'd0);
`endif

        // ID register is read-only
        xfer(0, 1'b0, 1'b0, 32'd0, 32'd0);
        xfer(0, 1'b1, 1'b0, 32'd0, 32'hDEAD_BEEF);
        xfer(0, 1'b0, 1'b0, 32'd0, 32'd0);

        // scratch write/read-back, ctrl untouched
        xfer(0, 1'b1, 1'b0, 32'd5, 32'h1234_5678);
        xfer(0, 1'b0, 1'b0, 32'd5, 32'd0);

        // inhibited write to ctrl
        xfer(0, 1'b1, 1'b1, 32'd1, 32'hFFFF_FFFF);
        xfer(0, 1'b0, 1'b0, 32'd1, 32'd0);

        // control write takes effect
        xfer(0, 1'b1, 1'b0, 32'd1, 32'hA5A5_0F0F);
        xfer(0, 1'b0, 1'b0, 32'd1, 32'd0);

        // wait states: latency 4, abort drops the write
        xfer(1, 1'b0, 1'b0, 32'd0, 32'd0);
        abort_write(1, 32'd6, 32'hA5A5_A5A5);
        xfer(1, 1'b0, 1'b0, 32'd6, 32'd0);
        abort_write(1, 32'd1, 32'h0000_00FF);
        check("abort_ctrl", ctrl1, 32'd0);

        // out-of-range addresses
        xfer(0, 1'b0, 1'b0, 32'h0000_0100, 32'd0);
        xfer(0, 1'b1, 1'b0, 32'h0000_0101, 32'h7777_7777);
        xfer(0, 1'b1, 1'b0, 32'h8000_0007, 32'h6666_6666);
        xfer(0, 1'b0, 1'b0, 32'd7, 32'd0);

        // strobe without sel is ignored
        addr[0] = 32'd9; wdat[0] = 32'h1111_2222; we[0] = 1'b1;
        cyc[0] = 1'b1; str[0] = 1'b1; sel[0] = 1'b0;
        n = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (ack_of(0)) n++;
        end
        check("nosel_no_ack", n, 0);
        bus_idle(0);
        @(posedge clk); #1;
        xfer(0, 1'b0, 1'b0, 32'd9, 32'd0);

        // random traffic on both instances
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 40; k++) begin
                a = 32'($urandom_range(0, 15));
                if ($urandom_range(0, 7) == 0) a = a | (32'd1 << $urandom_range(4, 31));
                xfer(d, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                     a, $urandom);
                repeat ($urandom_range(0, 2)) @(posedge clk);
                #1;
            end
            for (int i = 0; i < 16; i++) xfer(d, 1'b0, 1'b0, 32'(i), 32'd0);
        end

`ifdef WB_SLAVE_INTERRUPT_EN
        // interrupt: enable bit 0, pulse source, clear by W1C
        xfer(0, 1'b1, 1'b0, 32'd3, 32'd1);
        irq0 = 32'd1;
        n = 0;
        while (!int0 && n < 6) begin
            @(posedge clk); #1;
            n++;
        end
        check("int_set", 32'(int0), 32'd1);
        irq0 = 32'd0;
        mregs[0][2] = mregs[0][2] | 32'd1;
        xfer(0, 1'b0, 1'b0, 32'd2, 32'd0);
        xfer(0, 1'b1, 1'b0, 32'd2, 32'd1);
        check("int_hold", 32'(int0), 32'd1);
        @(posedge clk); #1;
        check("int_clear", 32'(int0), 32'd0);
        xfer(0, 1'b0, 1'b0, 32'd2, 32'd0);
`endif

        // reset while ack is high discards the pending write
        xfer(0, 1'b1, 1'b0, 32'd1, 32'h0F0F_0F0F);
        xfer(1, 1'b1, 1'b0, 32'd1, 32'h3C3C_3C3C);
        addr[0] = 32'd8; wdat[0] = 32'h5555_AAAA; we[0] = 1'b1; msk[0] = 1'b0;
        cyc[0] = 1'b1; str[0] = 1'b1; sel[0] = 1'b1;
        n = 0;
        while (!ack_of(0) && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("rst_pre_ack", 32'(ack_of(0)), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_ack", 32'(ack_of(0)), 32'd0);
        check("midrst_dat", dat_of(0), 32'd0);
        check("midrst_ctrl0", ctrl0, 32'd0);
        check("midrst_ctrl1", ctrl1, 32'd0);
        check("midrst_state", 32'(st0), 32'(ST_IDLE));
        bus_idle(0);
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        xfer(0, 1'b0, 1'b0, 32'd8, 32'd0);
        xfer(0, 1'b0, 1'b0, 32'd5, 32'd0);
        xfer(0, 1'b0, 1'b0, 32'd1, 32'd0);
        xfer(1, 1'b0, 1'b0, 32'd1, 32'd0);
        xfer(0, 1'b0, 1'b0, 32'd0, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wishbone_slave_regs.md
Name: wishbone_slave_regs

Overview:
- Wishbone responder at the far end of the bus driven by the wishbone master.
- Decodes strobed bus cycles and serves a small register bank: read-only ID word, control word, scratch registers.
- Four-phase strobe/ack handshake with programmable wait states.
- Reference slave for bring-up of the master's read/write/stream commands; template for peripheral slaves.

Parameters:
- ADDR_BITS, 4, register index width; bank holds 2**ADDR_BITS 32-bit words.
- WAIT_STATES, 0, extra cycles (0..15) between strobe acceptance and ack.
- DEVICE_ID, 32'h00010001, constant returned at register 0.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- wb_addr_i  in  32  word address
- wb_dat_i  in  32  write data
- wb_dat_o  out  32  read data, valid while wb_ack_o=1
- wb_str_i  in  1  strobe
- wb_cyc_i  in  1  cycle valid
- wb_we_i  in  1  1=write, 0=read
- wb_msk_i  in  1  write inhibit: write is acked but not committed
- wb_sel_i  in  1  slave select; strobe ignored unless 1
- wb_ack_o  out  1  acknowledge
- ctrl_o  out  32  current control register (reg 1) for downstream logic

Behaviour:
- Clock is clk. Reset is rst, synchronous, active-high.
- Reset values:
  - wb_ack_o=0, wb_dat_o=0, ctrl_o=0.
  - All scratch registers 0.
  - FSM in IDLE, wait counter 0.
- Register map (index = wb_addr_i[ADDR_BITS-1:0]):
  - 0: DEVICE_ID, read-only; writes acked and ignored.
  - 1: control, R/W.
  - 2 and up: scratch, R/W.
- Out of range: any wb_addr_i bit above ADDR_BITS-1 nonzero. Reads return 0, writes ignored, ack still given.
- FSM states: IDLE, WAIT, ACK.
- IDLE:
  - cyc&str&sel=1 latches address, we, msk and data.
  - Goes to WAIT if WAIT_STATES>0, else to ACK.
- WAIT:
  - Counts WAIT_STATES cycles, then goes to ACK.
  - If cyc or str drops here: abort to IDLE, no ack, no write.
- ACK:
  - wb_ack_o=1.
  - wb_dat_o holds read data (0 on writes).
  - Write commits on the first ACK cycle only, and only if msk=0 and the index is writable.
  - wb_ack_o stays high until str=0 or cyc=0, then drops on the next edge and the FSM returns to IDLE.
  - A new strobe is accepted no earlier than the cycle after ack drops.
- Latency, strobe to ack rising: 1+WAIT_STATES cycles, i.e. ack is visible 1 cycle after strobe is sampled when WAIT_STATES=0.
- wb_dat_o returns to 0 when ack drops.
- Read-after-write: a read of the same register in the next transaction returns the new value.
- rst asserted mid-transaction:
  - ack drops on the next edge; FSM to IDLE.
  - Registers reset; a pending write is discarded.
- Inputs sampled while sel=0 or cyc=0 are ignored entirely.

Optional Feature:
- Macro: WB_SLAVE_INTERRUPT_EN.
- Defined:
  - Adds ports irq_src_i (in, 32) and wb_int_o (out, 1).
  - Reg 2: pending. Set bitwise on an irq_src_i rising edge; write-1-to-clear. If set and clear coincide, set wins.
  - Reg 3: enable mask, R/W.
  - wb_int_o = |(pending & enable), registered (1-cycle delay), reset 0.
  - Scratch starts at reg 4.
- Undefined: those ports are absent; regs 2 and 3 are ordinary scratch.

Decomposition:
- Shared package/include `wishbone_defs`:
  - Register index constants (REG_ID=0, REG_CTRL=1, REG_IRQ_PEND=2, REG_IRQ_EN=3).
  - FSM state encodings.
  - Default DEVICE_ID.
- The master's command codes are also moved into `wishbone_defs`.
- One sub-module, `wb_slave_handshake`: the IDLE/WAIT/ACK FSM plus wait counter, exporting access strobe, latched address and we.
- Register bank stays in the top.

Test Plan:
- Read reg 0, WAIT_STATES=0 -> ack 1 cycle after strobe, wb_dat_o=32'h00010001; write 32'hDEADBEEF to reg 0 -> acked, reread still 32'h00010001.
- Write 32'h12345678 to reg 5, then read reg 5 -> 32'h12345678; ctrl_o unchanged at 0.
- Write with msk=1 to reg 1 with 32'hFFFFFFFF -> acked, ctrl_o stays 0; read reg 1 -> 0.
- WAIT_STATES=3: strobe -> ack rises 4 cycles later; drop str in the 2nd wait cycle -> no ack, no write.
- Address 32'h00000100 with ADDR_BITS=4 -> read returns 0, write ignored, ack given; assert rst while ack is high -> ack 0 next cycle, all regs 0.
- With WB_SLAVE_INTERRUPT_EN: enable=32'h1, pulse irq_src_i[0] -> wb_int_o=1; write 32'h1 to reg 2 -> wb_int_o=0 one cycle after the commit.
